bus6502_target: RTL and testbench
=================================

# bus6502_target

Bus responder for the `cpu6502` core: the target end of the CPU address/data/rw bus. It holds on-chip RAM and the hardware vector bytes, plus an optional memory-mapped interval timer that drives the CPU's active-low `irq` input. Bench and FPGA top levels instantiate it in place of ad-hoc ROM modules so that programs can store, reload and take interrupts.

## Interface
Parameters:
- `RAM_AW`, 11: RAM address width; RAM occupies `0x0000` to `2**RAM_AW-1`.
- `RESET_VEC`, 16'h0200: value returned at `0xFFFC`/`0xFFFD`.
- `IRQ_VEC`, 16'h0300: value returned at `0xFFFE`/`0xFFFF`.
- `NMI_VEC`, 16'h0380: value returned at `0xFFFA`/`0xFFFB`.
- `TMR_BASE`, 16'hD000: base address of the 4 timer registers.

Ports:
- `clk` in 1: system clock, the same clock that feeds `cpu6502`.
- `reset` in 1: asynchronous, active-high reset.
- `addr` in 16: CPU address.
- `wdata` in 8: CPU write data (CPU `odata`).
- `rw` in 1: 1 = read, 0 = write.
- `clk2` in 1: CPU phi2 output. Synchronous to `clk`.
- `rdata` out 8: read data (CPU `idata`).
- `irq_n` out 1: active-low interrupt request to the CPU.

## Operation
- Edge detection: register `clk2` as `clk2_q`.
  - `p2_rise = clk2 & ~clk2_q`.
  - `p2_fall = ~clk2 & clk2_q`.
- Writes commit on the `clk` edge where `p2_rise` is high and `rw == 0`. At most one write per CPU cycle.
- Reads: `rdata` is registered. Each `clk`, `rdata` loads the decoded value for the current `addr`.
- Decode priority:
  - RAM range.
  - Vector bytes `0xFFFA` to `0xFFFF` (little-endian; read-only, writes ignored).
  - Timer registers at `TMR_BASE+0..3`.
  - Everything else reads `0xFF`, and writes to it are dropped.
- Timer registers:
  - +0 `LATL`: reload value, low byte (R/W).
  - +1 `LATH`: reload value, high byte (R/W). Writing it also loads the counter with `{wdata, LATL}` and clears `FLAG`.
  - +2 `CTRL`: bit0 `EN`, bit1 `IE`, bit2 `CONT` (1 = auto-reload, 0 = one-shot). Bits 7:3 read 0.
  - +3 `STAT`: bit7 `FLAG`; other bits read 0. Writing 1 to bit7 clears `FLAG`.
- Counter: 16-bit. On each `p2_fall` with `EN` set:
  - If count ≠ 0, decrement.
  - If count == 0, set `FLAG`, then:
    - `CONT` = 1: reload from the latch.
    - `CONT` = 0: clear `EN`, counter stays 0.
  - A period of N CPU cycles therefore fires after N+1 falls.
- `irq_n = ~(FLAG & IE)`, registered.

## Timing
- Reset values:
  - `rdata = 0xFF`, `irq_n = 1`, `clk2_q = 0`.
  - `LATL = LATH = CTRL = 0`, `FLAG = 0`, counter = 0.
  - RAM contents are not reset.
- Read latency: 1 `clk` after `addr` changes. `rdata` must be stable before the `p2_fall` that ends the cycle.
- Write data is sampled with the `addr` present at `p2_rise`.
- `irq_n` changes 1 `clk` after `FLAG` or `IE` changes.
- Boundary conditions:
  - Underflow on the same `clk` as a `STAT` clear write: set wins, so `FLAG` stays 1.
  - `LATH` write on the same `clk` as an underflow: the load wins and `FLAG` stays cleared.
  - `CTRL` write on the same `clk` as a one-shot auto-clear of `EN`: the written value wins.
  - Reset asserted mid-countdown: timer state returns to reset values immediately; `irq_n` goes 1 asynchronously.

## Configuration
- `BUS6502_TIMER_EN` defined: the timer, its registers and `irq_n` logic are built as described above.
- `BUS6502_TIMER_EN` undefined: no timer logic.
  - `TMR_BASE+0..3` decode as unmapped (read `0xFF`, writes dropped).
  - `irq_n` is tied to 1.

## Structure
- Package `bus6502_pkg` holds:
  - Vector addresses (`VEC_NMI`, `VEC_RESET`, `VEC_IRQ`).
  - Timer register offsets and `CTRL`/`STAT` bit positions.
  - The unmapped read value `0xFF`.
- One sub-module, `bus6502_timer`, holds:
  - Latches, counter, `CTRL`, `FLAG` and `irq_n`.
  - Ports: `clk`, `reset`, write strobe, register offset, `wdata`, `tick` (= `p2_fall`), `rd_val`, `irq_n`.
- The top level holds the `clk2` edge detect, decode, RAM array and `rdata` register.

## Test plan
- Store then reload: CPU `STA $99` with A = `0xF7`, then `LDA $99` → write at `0x0099` commits on `p2_rise`; read returns `0xF7`.
- Vector fetch after reset: with defaults, the CPU reads `0xFFFC`/`0xFFFD` as `0x00`/`0x02` and the next fetch is at `0x0200`. A write to `0xFFFC` leaves it at `0x00`.
- Unmapped access: read `0x8000` → `0xFF`. Write `0x55` to `0x8000`, read back → `0xFF`.
- One-shot interrupt: write `LATL = 0x03`, `LATH = 0x00`, `CTRL = 0x03` → `irq_n` falls 1 `clk` after the 4th `p2_fall`. `STAT` reads `0x80`. Write `STAT = 0x80` → `irq_n` returns to 1; `CTRL` reads `0x02`.
- Continuous mode with a racing clear: `CTRL = 0x07`, latch = 2 → `FLAG` sets every 3 falls. A `STAT` clear written on the underflow `clk` leaves `FLAG = 1`.
- Reset mid-countdown: assert `reset` with the counter at 5 and `IE = 1` → `irq_n = 1`, `CTRL = 0`, `rdata = 0xFF`. No `FLAG` ever sets after reset is released.

Source files
------------

// File: rtl/bus6502_pkg.sv
// Shared constants for the 6502 bus target: vector addresses, timer register map, unmapped value.
// Latency: none (package of constants and a pure function).
// Backpressure: none.
package bus6502_pkg;

  // Hardware vector byte addresses (low byte of each little-endian pair)
  localparam logic [15:0] VEC_NMI   = 16'hFFFA;
  localparam logic [15:0] VEC_RESET = 16'hFFFC;
  localparam logic [15:0] VEC_IRQ   = 16'hFFFE;

  // Timer register offsets from the timer base address
  typedef enum logic [1:0] {
    TMR_LATL = 2'd0,
    TMR_LATH = 2'd1,
    TMR_CTRL = 2'd2,
    TMR_STAT = 2'd3
  } tmr_reg_e;

  // CTRL and STAT bit positions
  localparam int CTRL_EN   = 0;
  localparam int CTRL_IE   = 1;
  localparam int CTRL_CONT = 2;
  localparam int STAT_FLAG = 7;

  // Value seen on reads of addresses nothing responds to
  localparam logic [7:0] UNMAPPED_RD = 8'hFF;

  // Selects one byte of the vector table from the low three address bits
  function automatic logic [7:0] vec_byte(input logic [2:0]  lo,
                                          input logic [15:0] nmi_vec,
                                          input logic [15:0] reset_vec,
                                          input logic [15:0] irq_vec);
    logic [7:0] v;
    v = UNMAPPED_RD;
    case (lo)
      VEC_NMI[2:0]:          v = nmi_vec[7:0];
      VEC_NMI[2:0] + 3'd1:   v = nmi_vec[15:8];
      VEC_RESET[2:0]:        v = reset_vec[7:0];
      VEC_RESET[2:0] + 3'd1: v = reset_vec[15:8];
      VEC_IRQ[2:0]:          v = irq_vec[7:0];
      VEC_IRQ[2:0] + 3'd1:   v = irq_vec[15:8];
      default:               v = UNMAPPED_RD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bus6502_timer.sv
// Interval timer: 16-bit down counter with reload latch, control, sticky flag and registered irq_n.
// Latency: register writes take effect on the strobe clk; irq_n follows FLAG/IE one clk later.
// Backpressure: none; writes and ticks are accepted every clk.
module bus6502_timer
  import bus6502_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_wr,
  input  tmr_reg_e   i_off,
  input  logic [7:0] i_wdata,
  input  logic       i_tick,
  output logic [7:0] o_rd_val,
  output logic       o_irq_n
);

  logic [7:0]  r_latl;
  logic [7:0]  r_lath;
  logic [2:0]  r_ctrl;
  logic        r_flag;
  logic [15:0] r_cnt;
  logic        r_irq_n;

  logic w_run;
  logic w_underflow;
  logic w_wr_latl;
  logic w_wr_lath;
  logic w_wr_ctrl;
  logic w_wr_stat;

  assign w_run       = i_tick & r_ctrl[CTRL_EN];
  assign w_underflow = w_run & (r_cnt == 16'h0000);
  assign w_wr_latl   = i_wr & (i_off == TMR_LATL);
  assign w_wr_lath   = i_wr & (i_off == TMR_LATH);
  assign w_wr_ctrl   = i_wr & (i_off == TMR_CTRL);
  assign w_wr_stat   = i_wr & (i_off == TMR_STAT);

  // Timer state: a LATH load beats an underflow, an underflow beats a STAT clear,
  // and a CTRL write beats the one-shot auto-clear of EN.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_latl  <= 8'h00;
      r_lath  <= 8'h00;
      r_ctrl  <= 3'b000;
      r_flag  <= 1'b0;
      r_cnt   <= 16'h0000;
      r_irq_n <= 1'b1;
    end else begin
      if (w_wr_latl) r_latl <= i_wdata;
      if (w_wr_lath) r_lath <= i_wdata;

      if (w_wr_lath) begin
        r_cnt <= {i_wdata, r_latl};
      end else if (w_run) begin
        if (r_cnt != 16'h0000) begin
          r_cnt <= r_cnt - 16'd1;
        end else if (r_ctrl[CTRL_CONT]) begin
          r_cnt <= {r_lath, r_latl};
        end
      end

      if (w_wr_ctrl) begin
        r_ctrl <= i_wdata[2:0];
      end else if (w_underflow && !r_ctrl[CTRL_CONT]) begin
        r_ctrl[CTRL_EN] <= 1'b0;
      end

      if (w_wr_lath) begin
        r_flag <= 1'b0;
      end else if (w_underflow) begin
        r_flag <= 1'b1;
      end else if (w_wr_stat && i_wdata[STAT_FLAG]) begin
        r_flag <= 1'b0;
      end

      r_irq_n <= ~(r_flag & r_ctrl[CTRL_IE]);
    end
  end

  // Register readback for the bus read mux
  always_comb begin
    o_rd_val = 8'h00;
    case (i_off)
      TMR_LATL: o_rd_val = r_latl;
      TMR_LATH: o_rd_val = r_lath;
      TMR_CTRL: o_rd_val = {5'b00000, r_ctrl};
      TMR_STAT: o_rd_val = {r_flag, 7'b0000000};
      default:  o_rd_val = 8'h00;
    endcase
  end

  assign o_irq_n = r_irq_n;

endmodule

// File: rtl/bus6502_target.sv
// 6502 bus responder: RAM, vector bytes and (with BUS6502_TIMER_EN defined) an interval timer driving irq_n.
// Latency: rdata registered, 1 clk after addr; writes commit on the clk where clk2 rises with rw low.
// Backpressure: none; the CPU's clk2 phase sets the access rate and the target is always ready.
module bus6502_target
  import bus6502_pkg::*;
#(
  parameter int          RAM_AW    = 11,
  parameter logic [15:0] RESET_VEC = 16'h0200,
  parameter logic [15:0] IRQ_VEC   = 16'h0300,
  parameter logic [15:0] NMI_VEC   = 16'h0380,
  parameter logic [15:0] TMR_BASE  = 16'hD000
)
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_wdata,
  input  logic        i_rw,
  input  logic        i_clk2,
  output logic [7:0]  o_rdata,
  output logic        o_irq_n
);

  localparam int RAM_DEPTH = 1 << RAM_AW;

  logic              r_clk2_q;
  logic [7:0]        r_rdata;
  logic [7:0]        r_ram [RAM_DEPTH];

  logic              w_p2_rise;
  logic              w_wr;
  logic              w_in_ram;
  logic              w_in_vec;
  logic              w_in_tmr;
  logic [15:0]       w_tmr_off;
  logic [7:0]        w_tmr_rd;
  logic [7:0]        w_rd_val;
  logic [RAM_AW-1:0] w_ram_idx;

  assign w_p2_rise = i_clk2 & ~r_clk2_q;
  assign w_wr      = w_p2_rise & ~i_rw;

  // Address decode; the read mux and write strobes apply RAM > vectors > timer priority
  assign w_in_ram  = ((i_addr >> RAM_AW) == 16'h0000);
  assign w_in_vec  = (i_addr >= VEC_NMI);
  assign w_tmr_off = i_addr - TMR_BASE;
  assign w_in_tmr  = (w_tmr_off < 16'd4);
  assign w_ram_idx = i_addr[RAM_AW-1:0];

  // Previous clk2 level for phase edge detection
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_clk2_q <= 1'b0;
    end else begin
      r_clk2_q <= i_clk2;
    end
  end

  // RAM write port; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_wr && w_in_ram) begin
      r_ram[w_ram_idx] <= i_wdata;
    end
  end

`ifdef BUS6502_TIMER_EN
  logic w_p2_fall;
  logic w_tmr_wr;

  assign w_p2_fall = ~i_clk2 & r_clk2_q;
  assign w_tmr_wr  = w_wr & w_in_tmr & ~w_in_ram & ~w_in_vec;

  bus6502_timer u_timer (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_wr     (w_tmr_wr),
    .i_off    (tmr_reg_e'(w_tmr_off[1:0])),
    .i_wdata  (i_wdata),
    .i_tick   (w_p2_fall),
    .o_rd_val (w_tmr_rd),
    .o_irq_n  (o_irq_n)
  );
`else
  assign w_tmr_rd = UNMAPPED_RD;
  assign o_irq_n  = 1'b1;
`endif

  // Read mux for the current address
  always_comb begin
    w_rd_val = UNMAPPED_RD;
    if (w_in_ram) begin
      w_rd_val = r_ram[w_ram_idx];
    end else if (w_in_vec) begin
      w_rd_val = vec_byte(i_addr[2:0], NMI_VEC, RESET_VEC, IRQ_VEC);
    end else if (w_in_tmr) begin
      w_rd_val = w_tmr_rd;
    end
  end

  // Registered read data, reloaded every clk
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_rdata <= UNMAPPED_RD;
    end else begin
      r_rdata <= w_rd_val;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: tb/tb_bus6502_target.sv
// Bench for bus6502_target: emulated 3-clk CPU cycles, expectations queued, monitor compares on strobes.
// Latency: reads checked one clk after rdata loads; irq_n checked after the first and second clk of a cycle.
// Backpressure: none.
module tb_bus6502_target;
  import bus6502_pkg::*;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] addr  = 16'h0000;
  logic [7:0]  wdata = 8'h00;
  logic        rw    = 1'b1;
  logic        clk2  = 1'b0;
  logic [7:0]  rdata;
  logic        irq_n;

  always #5 clk = ~clk;

  bus6502_target dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_addr  (addr),
    .i_wdata (wdata),
    .i_rw    (rw),
    .i_clk2  (clk2),
    .o_rdata (rdata),
    .o_irq_n (irq_n)
  );

`ifdef BUS6502_TIMER_EN
  logic       t_wr    = 1'b0;
  logic       t_tick  = 1'b0;
  tmr_reg_e   t_off   = TMR_LATL;
  logic [7:0] t_wdata = 8'h00;
  logic [7:0] t_rd;
  logic       t_irq_n;

  bus6502_timer u_tmr (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_wr     (t_wr),
    .i_off    (t_off),
    .i_wdata  (t_wdata),
    .i_tick   (t_tick),
    .o_rd_val (t_rd),
    .o_irq_n  (t_irq_n)
  );
`endif

  // kind 0: rdata, 1: irq_n (bit 0), 2: standalone timer readback
  typedef struct {
    string      nm;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   mon_n  = 0;
  int   checks = 0;
  int   errors = 0;

  // Monitor: on each strobe, pop the queued expectations and compare with the DUT
  always @(negedge clk) begin
    exp_t       e;
    logic [7:0] act;
    for (int k = 0; k < mon_n; k++) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underrun got strobe expected queued entry");
      end else begin
        e   = sb.pop_front();
        act = 8'hxx;
        case (e.kind)
          0: act = rdata;
          1: act = {7'b0000000, irq_n};
`ifdef BUS6502_TIMER_EN
          2: act = t_rd;
`endif
          default: act = 8'hxx;
        endcase
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s got %02h expected %02h", e.nm, act, e.val);
        end
      end
    end
  end

  task automatic expect_val(input string nm, input int kind, input logic [7:0] v);
    exp_t e;
    e.nm   = nm;
    e.kind = kind;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic strobe(input int n);
    mon_n = n;
    @(negedge clk);
    #1;
    mon_n = 0;
  endtask

  // One CPU cycle, entered and left at posedge+1.
  // E1: previous clk2 fall seen, rdata loads; E2: clk2 rise, write commits; E3: clk2 drops.
  task automatic bus_cycle(input logic [15:0] a, input logic r, input logic [7:0] d,
                           input string nm, input bit crd, input logic [7:0] erd,
                           input bit cia, input logic eia, input bit cib, input logic eib);
    int n;
    addr  = a;
    rw    = r;
    wdata = d;
    @(posedge clk); #1;
    clk2 = 1'b1;
    if (cia) begin
      expect_val({nm, "_irqA"}, 1, {7'b0000000, eia});
      strobe(1);
    end
    @(posedge clk); #1;
    n = 0;
    if (crd) begin expect_val(nm, 0, erd); n++; end
    if (cib) begin expect_val({nm, "_irqB"}, 1, {7'b0000000, eib}); n++; end
    if (n > 0) strobe(n);
    @(posedge clk); #1;
    clk2 = 1'b0;
    rw   = 1'b1;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus_cycle(a, 1'b0, d, "wr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] e, input string nm);
    bus_cycle(a, 1'b1, 8'h5A, nm, 1'b1, e, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

`ifdef BUS6502_TIMER_EN
  task automatic tmr_step(input bit w, input tmr_reg_e off, input logic [7:0] d, input bit tk);
    t_wr    = w;
    t_off   = off;
    t_wdata = d;
    t_tick  = tk;
    @(posedge clk); #1;
    t_wr   = 1'b0;
    t_tick = 1'b0;
  endtask

  task automatic tmr_read(input tmr_reg_e off, input logic [7:0] e, input string nm);
    t_off = off;
    expect_val(nm, 2, e);
    strobe(1);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    expect_val("reset_rdata", 0, 8'hFF);
    expect_val("reset_irq_n", 1, 8'h01);
    strobe(2);
    @(posedge clk); #1;
    reset = 1'b0;

    // Vector bytes, read-only
    rd(16'hFFFC, 8'h00, "vec_reset_lo");
    rd(16'hFFFD, 8'h02, "vec_reset_hi");
    rd(16'hFFFA, 8'h80, "vec_nmi_lo");
    rd(16'hFFFB, 8'h03, "vec_nmi_hi");
    rd(16'hFFFE, 8'h00, "vec_irq_lo");
    rd(16'hFFFF, 8'h03, "vec_irq_hi");
    wr(16'hFFFC, 8'h12);
    rd(16'hFFFC, 8'h00, "vec_write_ignored");

    // Store then reload, RAM edges, no aliasing past the top of RAM
    wr(16'h0099, 8'hF7);
    rd(16'h0099, 8'hF7, "ram_store_reload");
    wr(16'h0000, 8'h11);
    wr(16'h07FF, 8'hA5);
    wr(16'h0200, 8'hEA);
    wr(16'h0800, 8'h33);
    rd(16'h07FF, 8'hA5, "ram_top");
    rd(16'h0800, 8'hFF, "above_ram_unmapped");
    rd(16'h0000, 8'h11, "ram_no_alias");
    rd(16'h0200, 8'hEA, "ram_reset_target");
    rd(16'h0099, 8'hF7, "ram_read_no_write");

    // Unmapped space
    rd(16'h8000, 8'hFF, "unmapped_rd");
    wr(16'h8000, 8'h55);
    rd(16'h8000, 8'hFF, "unmapped_wr_dropped");

`ifdef BUS6502_TIMER_EN
    // One-shot: period 3 fires on the 4th fall, irq_n one clk later
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    for (int i = 0; i < 3; i++)
      bus_cycle(16'h8000, 1'b1, 8'h00, "os_wait", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
    bus_cycle(16'h8000, 1'b1, 8'h00, "os_fire", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    bus_cycle(16'hD003, 1'b1, 8'h00, "os_stat", 1'b1, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0);
    bus_cycle(16'hD003, 1'b0, 8'h80, "os_clr", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    bus_cycle(16'hD002, 1'b1, 8'h00, "os_ctrl", 1'b1, 8'h02, 1'b1, 1'b1, 1'b1, 1'b1);
    rd(16'hD000, 8'h03, "latl_rb");

    // Continuous: latch 2 sets FLAG every 3 falls
    wr(16'hD000, 8'h02);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h07);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_j1", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_j2", 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_j3", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    wr(16'hD003, 8'h80);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_j5", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_j6", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h80);
    bus_cycle(16'h8000, 1'b1, 8'h00, "ct_off", 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);

    // Same-clk races on the timer itself
    tmr_step(1'b1, TMR_LATL, 8'h02, 1'b0);
    tmr_step(1'b1, TMR_LATH, 8'h00, 1'b0);
    tmr_step(1'b1, TMR_CTRL, 8'h07, 1'b0);
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b1, TMR_STAT, 8'h80, 1'b1);
    tmr_read(TMR_STAT, 8'h80, "race_set_beats_clear");
    tmr_step(1'b1, TMR_STAT, 8'h80, 1'b0);
    tmr_read(TMR_STAT, 8'h00, "stat_clear");
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b1, TMR_LATH, 8'h01, 1'b1);
    tmr_read(TMR_STAT, 8'h00, "race_lath_beats_set");
    tmr_read(TMR_LATH, 8'h01, "lath_rb");
    tmr_step(1'b1, TMR_LATH, 8'h00, 1'b0);
    tmr_step(1'b1, TMR_CTRL, 8'h01, 1'b0);
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b0, TMR_LATL, 8'h00, 1'b1);
    tmr_step(1'b1, TMR_CTRL, 8'h05, 1'b1);
    tmr_read(TMR_CTRL, 8'h05, "race_ctrl_beats_autoclr");
    tmr_read(TMR_STAT, 8'h80, "race_ctrl_flag");
    tmr_step(1'b1, TMR_CTRL, 8'h00, 1'b0);
    @(posedge clk); #1;

    // Countdown to 5 with IE set before the mid-run reset
    wr(16'hD000, 8'h07);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    rd(16'h8000, 8'hFF, "count_wait");
`else
    // Timer window behaves as unmapped space
    wr(16'hD002, 8'h03);
    rd(16'hD000, 8'hFF, "notmr_latl");
    bus_cycle(16'hD002, 1'b1, 8'h00, "notmr_ctrl", 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1);
    rd(16'hD003, 8'hFF, "notmr_stat");
`endif

    // Reset mid-run: rdata and irq_n return immediately, RAM survives
    rd(16'h0099, 8'hF7, "pre_reset");
    #2;
    reset = 1'b1;
    expect_val("async_reset_rdata", 0, 8'hFF);
    expect_val("async_reset_irq_n", 1, 8'h01);
    strobe(2);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(16'h0099, 8'hF7, "ram_kept_over_reset");
`ifdef BUS6502_TIMER_EN
    rd(16'hD002, 8'h00, "ctrl_after_reset");
    rd(16'hD000, 8'h00, "latl_after_reset");
    for (int i = 0; i < 10; i++)
      bus_cycle(16'hD003, 1'b1, 8'h00, "no_flag_after_reset", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
`else
    bus_cycle(16'hD002, 1'b1, 8'h00, "notmr_after_reset", 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b1);
`endif

    repeat (2) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
